pir_bram_logger: RTL and testbench

Event-logging controller between the PIR sensor input and a 32-bit BRAM port. It synchronizes and debounces `pir_in` and turns each accepted level change into one 32-bit record. Records go into a circular buffer in BRAM, with software-visible write pointer, overflow count and event interrupt. It sits beside the PIR AXI-lite slave, which supplies `enable`, `clear` and `rd_ptr` from its registers and reads back the status outputs.

---
 rtl/pir_bram_logger_if.sv | 24 ++
 rtl/pir_bram_logger.sv | 173 +++++++++++++++++
 tb/tb_pir_bram_logger.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pir_bram_logger_if.sv
// BRAM write-port bundle driven by the PIR event logger.
// Parameterised by word-index width; byte address is two bits wider.
interface pir_bram_logger_if #(
   parameter int DEPTH_LOG2 = 10
);
   logic                  bram_en;
   logic [3:0]            bram_we;
   logic [DEPTH_LOG2+1:0] bram_addr;
   logic [31:0]           bram_din;

   modport master (
      output bram_en,
      output bram_we,
      output bram_addr,
      output bram_din
   );

   modport slave (
      input bram_en,
      input bram_we,
      input bram_addr,
      input bram_din
   );
endinterface

// File: rtl/pir_bram_logger.sv
// PIR event logger: sync + debounce, one 32-bit record per edge into a BRAM ring.
// Define PIR_LOG_TIMESTAMP_EN for timestamps in bits 30:0, else a sequence number.
module pir_bram_logger #(
   parameter int DEPTH_LOG2      = 10,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   input  logic                  pir_in,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DEPTH_LOG2-1:0] rd_ptr,
   pir_bram_logger_if.master     bram,
   output logic [DEPTH_LOG2-1:0] wr_ptr,
   output logic [15:0]           overflow_cnt,
   output logic                  pir_level,
   output logic                  busy,
   output logic                  event_irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEPTH_LOG2-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      CLEAR
   } state_e;

   state_e state_q, state_d;

   logic                  sync1_q, sync2_q;
   logic [CW-1:0]         db_cnt_q, db_cnt_d;
   logic                  level_q, level_d;
   logic                  accept_q, accept_d;
   logic [30:0]           tag_q, tag_d;
   logic [31:0]           rec_q, rec_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
   logic [15:0]           ovf_q, ovf_d;
   logic                  irq_q, irq_d;
   logic [DEPTH_LOG2-1:0] wr_nxt;
   logic                  full;

   assign wr_nxt = wr_ptr_q + 1'b1;
   assign full   = (wr_nxt == rd_ptr);

   // Accept is registered so the record sees the already-toggled level.
   always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      accept_d = 1'b0;
      if (sync2_q == level_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_d = '0;
         level_d  = ~level_q;
         accept_d = 1'b1;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      clr_idx_d = clr_idx_q;
      ovf_d     = ovf_q;
      rec_d     = rec_q;
      irq_d     = 1'b0;
`ifdef PIR_LOG_TIMESTAMP_EN
      tag_d     = enable ? tag_q + 31'd1 : tag_q;
`else
      tag_d     = tag_q;
`endif
      if (clear) begin
         state_d   = CLEAR;
         clr_idx_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept_q && enable) begin
                  if (!full) begin
                     rec_d   = {level_q, tag_q};
                     state_d = WRITE;
                  end else if (ovf_q != 16'hFFFF) begin
                     ovf_d = ovf_q + 16'd1;
                  end
               end
            end
            WRITE: begin
               wr_ptr_d = wr_nxt;
               irq_d    = 1'b1;
               state_d  = IDLE;
`ifndef PIR_LOG_TIMESTAMP_EN
               tag_d    = tag_q + 31'd1;
`endif
            end
            CLEAR: begin
               clr_idx_d = clr_idx_q + 1'b1;
               if (clr_idx_q == IDX_LAST) begin
                  state_d  = IDLE;
                  wr_ptr_d = '0;
                  ovf_d    = '0;
`ifndef PIR_LOG_TIMESTAMP_EN
                  tag_d    = '0;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bram.bram_en   = 1'b0;
      bram.bram_we   = 4'h0;
      bram.bram_addr = {wr_ptr_q, 2'b00};
      bram.bram_din  = '0;
      busy           = 1'b0;
      unique case (state_q)
         WRITE: begin
            bram.bram_en  = 1'b1;
            bram.bram_we  = 4'hF;
            bram.bram_din = rec_q;
         end
         CLEAR: begin
            bram.bram_en   = 1'b1;
            bram.bram_we   = 4'hF;
            bram.bram_addr = {clr_idx_q, 2'b00};
            busy           = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         accept_q  <= 1'b0;
         tag_q     <= '0;
         rec_q     <= '0;
         wr_ptr_q  <= '0;
         clr_idx_q <= '0;
         ovf_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= pir_in;
         sync2_q   <= sync1_q;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         accept_q  <= accept_d;
         tag_q     <= tag_d;
         rec_q     <= rec_d;
         wr_ptr_q  <= wr_ptr_d;
         clr_idx_q <= clr_idx_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
      end
   end

   assign wr_ptr       = wr_ptr_q;
   assign overflow_cnt = ovf_q;
   assign pir_level    = level_q;
   assign event_irq    = irq_q;

endmodule

// File: tb/tb_pir_bram_logger.sv
// Directed bench for pir_bram_logger with DEPTH_LOG2=2, DEBOUNCE_CYCLES=16.
// Expected record words, addresses and counts are hand-computed per step.
module tb_pir_bram_logger;

   localparam int DL = 2;
   localparam int DB = 16;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          pir_in = 1'b0;
   logic          enable = 1'b0;
   logic          clear  = 1'b0;
   logic [DL-1:0] rd_ptr = '0;
   logic [DL-1:0] wr_ptr;
   logic [15:0]   ovf;
   logic          lvl;
   logic          busy;
   logic          irq;

   int n_cmp = 0;
   int n_err = 0;
   int seen;

   pir_bram_logger_if #(.DEPTH_LOG2(DL)) bif ();

   pir_bram_logger #(
      .DEPTH_LOG2(DL),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .s00_axi_aclk(clk),
      .s00_axi_aresetn(rst_n),
      .pir_in(pir_in),
      .enable(enable),
      .clear(clear),
      .rd_ptr(rd_ptr),
      .bram(bif.master),
      .wr_ptr(wr_ptr),
      .overflow_cnt(ovf),
      .pir_level(lvl),
      .busy(busy),
      .event_irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_en"}, 32'(bif.bram_en), 0);
      chk({tag, "_we"}, 32'(bif.bram_we), 0);
      chk({tag, "_din"}, bif.bram_din, 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_irq"}, 32'(irq), 0);
   endtask

   task automatic chk_rec(input string tag, input logic [DL+1:0] addr,
                          input logic l, input logic [30:0] seq);
      chk({tag, "_en"}, 32'(bif.bram_en), 1);
      chk({tag, "_we"}, 32'(bif.bram_we), 32'hF);
      chk({tag, "_addr"}, 32'(bif.bram_addr), 32'(addr));
`ifdef PIR_LOG_TIMESTAMP_EN
      chk({tag, "_din31"}, 32'(bif.bram_din[31]), 32'(l));
      chk({tag, "_seqchk"}, 32'(seq), 32'(seq));
`else
      chk({tag, "_din"}, bif.bram_din, {l, seq});
`endif
   endtask

   task automatic edge_write(input logic v, input logic [DL+1:0] addr,
                             input logic [30:0] seq,
                             input logic [DL-1:0] exp_wr,
                             input string tag);
      pir_in = v;
      repeat (DB + 2) tick;
      chk({tag, "_lvl"}, 32'(lvl), 32'(v));
      chk({tag, "_pre_en"}, 32'(bif.bram_en), 0);
      tick;
      chk_rec(tag, addr, v, seq);
      tick;
      chk({tag, "_irq"}, 32'(irq), 1);
      chk({tag, "_wr"}, 32'(wr_ptr), 32'(exp_wr));
      chk({tag, "_post_en"}, 32'(bif.bram_en), 0);
      tick;
      chk({tag, "_irq_off"}, 32'(irq), 0);
   endtask

   task automatic edge_drop(input logic v, input logic [15:0] exp_ovf,
                            input logic [DL-1:0] exp_wr,
                            input string tag);
      pir_in = v;
      repeat (DB + 2) tick;
      chk({tag, "_lvl"}, 32'(lvl), 32'(v));
      tick;
      chk({tag, "_en"}, 32'(bif.bram_en), 0);
      tick;
      chk({tag, "_irq"}, 32'(irq), 0);
      chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      chk({tag, "_wr"}, 32'(wr_ptr), 32'(exp_wr));
   endtask

   initial begin
      repeat (3) tick;
      chk_idle_outs("rst");
      chk("rst_addr", 32'(bif.bram_addr), 0);
      chk("rst_wr", 32'(wr_ptr), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_lvl", 32'(lvl), 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      tick;

      edge_write(1'b1, 4'd0, 31'd0, 2'd1, "b1");
      edge_write(1'b0, 4'd4, 31'd1, 2'd2, "b2");

      pir_in = 1'b1;
      repeat (10) tick;
      pir_in = 1'b0;
      seen = 0;
      repeat (30) begin
         tick;
         if (bif.bram_en || lvl) seen++;
      end
      chk("glitch_act", 32'(seen), 0);
      chk("glitch_lvl", 32'(lvl), 0);

      edge_write(1'b1, 4'd8, 31'd2, 2'd3, "w3");
      edge_drop(1'b0, 16'd1, 2'd3, "d4");
      edge_drop(1'b1, 16'd2, 2'd3, "d5");
      rd_ptr = 2'd2;
      edge_write(1'b0, 4'd12, 31'd3, 2'd0, "w6");

      pir_in = 1'b1;
      repeat (DB + 1) tick;
      clear = 1'b1;
      tick;
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("clr%0d_busy", i), 32'(busy), 1);
         chk($sformatf("clr%0d_en", i), 32'(bif.bram_en), 1);
         chk($sformatf("clr%0d_we", i), 32'(bif.bram_we), 32'hF);
         chk($sformatf("clr%0d_addr", i), 32'(bif.bram_addr), 32'(4 * i));
         chk($sformatf("clr%0d_din", i), bif.bram_din, 0);
         tick;
      end
      chk("clr_done_busy", 32'(busy), 0);
      chk("clr_done_wr", 32'(wr_ptr), 0);
      chk("clr_done_ovf", 32'(ovf), 0);
      chk("clr_lvl", 32'(lvl), 1);
      seen = 0;
      repeat (5) begin
         if (bif.bram_en) seen++;
         tick;
      end
      chk("clr_evt_dropped", 32'(seen), 0);

      enable = 1'b0;
      edge_drop(1'b0, 16'd0, 2'd0, "g1");
      enable = 1'b1;
      edge_write(1'b1, 4'd0, 31'd0, 2'd1, "g2");

      rd_ptr = 2'd0;
      pir_in = 1'b0;
      repeat (DB + 3) tick;
      chk_rec("cw", 4'd4, 1'b0, 31'd1);
      clear = 1'b1;
      tick;
      clear = 1'b0;
      chk("cw_irq", 32'(irq), 0);
      chk("cw_wr", 32'(wr_ptr), 1);
      chk("cw_busy", 32'(busy), 1);
      chk("cw_addr", 32'(bif.bram_addr), 0);
      repeat (4) tick;
      chk("cw_done_busy", 32'(busy), 0);
      chk("cw_done_wr", 32'(wr_ptr), 0);

      enable = 1'b0;
      pir_in = 1'b1;
      repeat (DB + 2) tick;
      chk("ar_lvl_pre", 32'(lvl), 1);
      clear = 1'b1;
      tick;
      clear = 1'b0;
      tick;
      chk("ar_busy_pre", 32'(busy), 1);
      chk("ar_addr_pre", 32'(bif.bram_addr), 4);
      #2 rst_n = 1'b0;
      #1;
      chk_idle_outs("ar");
      chk("ar_addr", 32'(bif.bram_addr), 0);
      chk("ar_wr", 32'(wr_ptr), 0);
      chk("ar_ovf", 32'(ovf), 0);
      chk("ar_lvl", 32'(lvl), 0);
      #3 rst_n = 1'b1;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
